// File: rtl/window_builder.sv
// 3x3 sliding-window generator over a raster pixel stream, using two line buffers
// and a 3x3 shift register; emits one window per pixel once two full rows and columns are in.
module window_builder #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        writeEnable,
  input  logic [7:0]  writeData,
  input  logic        frameStart,
  output logic [71:0] window,
  output logic        windowValid,
  output logic        frameDone
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] posCol;
  logic [ROW_W-1:0] posRow;

  logic [7:0] lb0 [WIDTH];
  logic [7:0] lb1 [WIDTH];
  logic [7:0] shiftReg [9];

  logic [7:0] topPix;
  logic [7:0] midPix;
  logic       lastCol;
  logic       lastRow;
  logic       inWindow;

  // frameStart redirects the current pixel to (0,0) without waiting a cycle
  always_comb begin
    posCol   = frameStart ? '0 : col;
    posRow   = frameStart ? '0 : row;
    topPix   = lb0[posCol];
    midPix   = lb1[posCol];
    lastCol  = (posCol == LAST_COL);
    lastRow  = (posRow == LAST_ROW);
    inWindow = (posCol >= COL_W'(2)) && (posRow >= ROW_W'(2));
  end

  always_ff @(posedge clk) begin
    if (writeEnable) begin
      lb0[posCol] <= midPix;
      lb1[posCol] <= writeData;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      col         <= '0;
      row         <= '0;
      windowValid <= 1'b0;
      frameDone   <= 1'b0;
      for (int k = 0; k < 9; k++) shiftReg[k] <= '0;
    end else begin
      windowValid <= writeEnable && inWindow;
      frameDone   <= writeEnable && lastCol && lastRow;
      if (writeEnable) begin
        for (int i = 0; i < 3; i++) begin
          shiftReg[3*i]   <= shiftReg[3*i+1];
          shiftReg[3*i+1] <= shiftReg[3*i+2];
        end
        shiftReg[2] <= topPix;
        shiftReg[5] <= midPix;
        shiftReg[8] <= writeData;
        if (!lastCol) begin
          col <= posCol + 1'b1;
          row <= posRow;
        end else begin
          col <= '0;
          row <= lastRow ? '0 : posRow + 1'b1;
        end
      end else if (frameStart) begin
        col <= '0;
        row <= '0;
      end
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_pack
    assign window[8*k +: 8] = shiftReg[k];
  end

endmodule

// File: tb/tb_window_builder.sv
// Scoreboard bench for window_builder on a 4x4 image: a position model predicts each
// window, pushes it when the pixel is driven, and the monitor pops it on windowValid.
module tb_window_builder;
  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        writeEnable = 1'b0;
  logic [7:0]  writeData = '0;
  logic        frameStart = 1'b0;
  logic [71:0] window;
  logic        windowValid;
  logic        frameDone;

  window_builder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .nRst(nRst), .writeEnable(writeEnable), .writeData(writeData),
    .frameStart(frameStart), .window(window), .windowValid(windowValid),
    .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int cycleCnt = 0;
  int validCnt = 0;
  int doneCnt = 0;
  logic [7:0] img [H][W];
  int mRow = 0;
  int mCol = 0;
  logic weAtEdge = 1'b0;
  logic [71:0] prevWin = '0;
  logic prevRstOk = 1'b0;

  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    weAtEdge <= writeEnable;
  end

  always @(negedge clk) begin
    if (!nRst) begin
      total++;
      assert (window === 72'h0 && windowValid === 1'b0 && frameDone === 1'b0)
      else begin
        bad++;
        $error("FAIL reset_out window=%h valid=%b done=%b required all zero", window, windowValid, frameDone);
      end
    end else begin
      if (windowValid === 1'b1) validCnt++;
      if (frameDone === 1'b1) doneCnt++;
      if (windowValid === 1'b1) begin
        total++;
        assert (sb.size() > 0)
        else begin
          bad++;
          $error("FAIL spurious_valid at cycle %0d, no window expected", cycleCnt);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++;
          assert (window === e.win)
          else begin
            bad++;
            $error("FAIL window got=%h required=%h", window, e.win);
          end
          total++;
          assert (frameDone === e.done)
          else begin
            bad++;
            $error("FAIL frame_done got=%b required=%b", frameDone, e.done);
          end
          total++;
          assert (cycleCnt === e.cyc)
          else begin
            bad++;
            $error("FAIL latency valid at cycle %0d required %0d", cycleCnt, e.cyc);
          end
        end
      end else begin
        total++;
        assert (frameDone === 1'b0)
        else begin
          bad++;
          $error("FAIL done_without_valid got=%b required=0", frameDone);
        end
        if (sb.size() > 0 && sb[0].cyc <= cycleCnt) begin
          total++;
          assert (windowValid === 1'b1)
          else begin
            bad++;
            $error("FAIL missed_valid got=%b required=1 at cycle %0d", windowValid, cycleCnt);
          end
          void'(sb.pop_front());
        end
        if (prevRstOk && !weAtEdge) begin
          total++;
          assert (window === prevWin)
          else begin
            bad++;
            $error("FAIL idle_stable got=%h required=%h", window, prevWin);
          end
        end
      end
    end
    prevWin = window;
    prevRstOk = nRst;
  end

  task automatic pix(input logic [7:0] d, input logic fs);
    logic [71:0] w;
    @(negedge clk);
    if (fs) begin
      mRow = 0;
      mCol = 0;
    end
    img[mRow][mCol] = d;
    if (mRow >= 2 && mCol >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[8*(3*i+j) +: 8] = img[mRow-2+i][mCol-2+j];
      sb.push_back('{win: w, done: (mRow == H-1 && mCol == W-1), cyc: cycleCnt + 1});
    end
    if (mCol < W-1) mCol++;
    else begin
      mCol = 0;
      mRow = (mRow == H-1) ? 0 : mRow + 1;
    end
    writeEnable = 1'b1;
    writeData = d;
    frameStart = fs;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    frameStart = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
    sb.delete();
    idle(2);
  endtask

  task automatic checkCounts(input string tag, input int v0, input int d0, input int v, input int d);
    total++;
    assert (validCnt - v0 == v)
    else begin
      bad++;
      $error("FAIL %s_valid_count got=%0d required=%0d", tag, validCnt - v0, v);
    end
    total++;
    assert (doneCnt - d0 == d)
    else begin
      bad++;
      $error("FAIL %s_done_count got=%0d required=%0d", tag, doneCnt - d0, d);
    end
  endtask

  initial begin
    int v0, d0;
    logic [71:0] firstWin;
    repeat (3) @(negedge clk);
    #2 nRst = 1'b1;
    idle(1);

    // Back-to-back frame, with the first window checked against literal bytes
    v0 = validCnt; d0 = doneCnt;
    for (int p = 0; p < 16; p++) pix(8'(p), 1'b0);
    firstWin = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    total++;
    assert (img[2][2] === 8'd10 && img[0][0] === 8'd0)
    else begin
      bad++;
      $error("FAIL model_image got=%0d required=10", img[2][2]);
    end
    drain();
    checkCounts("b2b", v0, d0, 4, 1);
    total++;
    assert (firstWin[71:64] === 8'd10)
    else begin
      bad++;
      $error("FAIL literal_pack got=%0d required=10", firstWin[71:64]);
    end

    // Random idle gaps between strobes
    v0 = validCnt; d0 = doneCnt;
    for (int p = 0; p < 16; p++) begin
      pix(8'(p), 1'b0);
      idle($urandom_range(0, 5));
    end
    drain();
    checkCounts("gaps", v0, d0, 4, 1);

    // Asynchronous reset in the middle of a frame
    for (int p = 0; p < 6; p++) pix(8'(p + 200), 1'b0);
    @(posedge clk);
    #2 nRst = 1'b0;
    mRow = 0;
    mCol = 0;
    repeat (3) @(negedge clk);
    #2 nRst = 1'b1;
    v0 = validCnt; d0 = doneCnt;
    for (int p = 0; p < 16; p++) pix(8'(p), 1'b0);
    drain();
    checkCounts("reset", v0, d0, 4, 1);

    // frameStart alone after a partial frame
    for (int p = 0; p < 6; p++) pix(8'(p + 150), 1'b0);
    @(negedge clk);
    frameStart = 1'b1;
    mRow = 0;
    mCol = 0;
    @(posedge clk);
    #1 frameStart = 1'b0;
    v0 = validCnt; d0 = doneCnt;
    for (int p = 0; p < 16; p++) pix(8'(p), 1'b0);
    drain();
    checkCounts("fstart", v0, d0, 4, 1);

    // Two consecutive frames, second opened with frameStart on its first pixel
    v0 = validCnt; d0 = doneCnt;
    for (int p = 0; p < 16; p++) pix(8'(p), 1'b0);
    for (int p = 0; p < 16; p++) pix(8'(p + 100), p == 0);
    drain();
    checkCounts("twoframe", v0, d0, 8, 2);

    // frameStart together with a pixel in the middle of a frame
    for (int p = 0; p < 5; p++) pix(8'(p + 30), 1'b0);
    v0 = validCnt; d0 = doneCnt;
    for (int p = 0; p < 16; p++) pix(8'(p + 50), p == 0);
    drain();
    checkCounts("fswe", v0, d0, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
